// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel down-counting timer.
package timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int unsigned CHANNELS_DEF       = 32'd4;
  localparam int unsigned SIZE_DEF           = 32'd32;
  localparam int unsigned PRESCALE_WIDTH_DEF = 32'd8;
  localparam int unsigned DEFAULT_PERIOD_DEF = 32'd40000000;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, latched period and mode, expiry pulse and
// sticky interrupt-pending flag. Advances only on the shared prescaler tick.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned SIZE           = SIZE_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic            start,
  input  logic            stop,
  input  logic            periodic,
  input  logic [SIZE-1:0] period,
  input  logic            ack,
  output logic            running,
  output logic            expired,
  output logic            irq_pending,
  output logic [SIZE-1:0] count
);

  localparam logic [SIZE-1:0] ONE_C     = SIZE'(1'b1);
  localparam logic [SIZE-1:0] DEFAULT_C = SIZE'(DEFAULT_PERIOD);

  logic [SIZE-1:0] count_r, count_s;
  logic [SIZE-1:0] period_r, period_s;
  logic [SIZE-1:0] load_s;
  logic            mode_r, mode_s;
  logic            expired_r, expired_s;
  logic            pending_r, pending_s;
  logic            running_r;

  // Next-state: start beats stop beats tick; expiry reloads only in periodic mode.
  always_comb begin
    load_s    = (period == '0) ? DEFAULT_C : period;
    count_s   = count_r;
    period_s  = period_r;
    mode_s    = mode_r;
    expired_s = 1'b0;
    if (start) begin
      count_s  = load_s;
      period_s = load_s;
      mode_s   = periodic;
    end else if (stop) begin
      count_s = '0;
    end else if (tick && (count_r != '0)) begin
      if (count_r == ONE_C) begin
        expired_s = 1'b1;
        count_s   = (mode_r == MODE_PERIODIC) ? period_r : '0;
      end else begin
        count_s = count_r - ONE_C;
      end
    end else begin
      count_s = count_r;
    end

    // Expiry wins over a coincident acknowledge so no event is lost.
    if (expired_s) begin
      pending_s = 1'b1;
    end else if (ack) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end
  end

  // Channel state registers; running is registered from the next count.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r   <= '0;
      period_r  <= '0;
      mode_r    <= MODE_ONESHOT;
      expired_r <= 1'b0;
      pending_r <= 1'b0;
      running_r <= 1'b0;
    end else begin
      count_r   <= count_s;
      period_r  <= period_s;
      mode_r    <= mode_s;
      expired_r <= expired_s;
      pending_r <= pending_s;
      running_r <= (count_s != '0);
    end
  end

  assign running     = running_r;
  assign expired     = expired_r;
  assign irq_pending = pending_r;
  assign count       = count_r;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: a shared free-running prescaler feeding CHANNELS
// independent one-shot/periodic down counters, plus a combined interrupt.
module timer_multi
  import timer_pkg::*;
#(
  parameter int unsigned CHANNELS       = CHANNELS_DEF,
  parameter int unsigned SIZE           = SIZE_DEF,
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PRESCALE_WIDTH-1:0]  prescale,
  input  logic [CHANNELS-1:0]        start,
  input  logic [CHANNELS-1:0]        stop,
  input  logic [CHANNELS-1:0]        periodic,
  input  logic [CHANNELS*SIZE-1:0]   period,
  input  logic [CHANNELS-1:0]        ack,
  output logic [CHANNELS-1:0]        running,
  output logic [CHANNELS-1:0]        expired,
  output logic [CHANNELS-1:0]        irq_pending,
  output logic                       irq,
  output logic [CHANNELS*SIZE-1:0]   count
);

  localparam logic [PRESCALE_WIDTH-1:0] PSC_ONE_C = PRESCALE_WIDTH'(1'b1);

  logic [PRESCALE_WIDTH-1:0] prescaler_r;
  logic                      tick_s;

  // Equality compare: lowering prescale below the current phase wraps the counter.
  assign tick_s = (prescaler_r == prescale);

  // Shared prescaler, restarting from zero on every tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler_r <= '0;
    end else if (tick_s) begin
      prescaler_r <= '0;
    end else begin
      prescaler_r <= prescaler_r + PSC_ONE_C;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .SIZE           (SIZE),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick_s),
      .start       (start[i]),
      .stop        (stop[i]),
      .periodic    (periodic[i]),
      .period      (period[i*SIZE +: SIZE]),
      .ack         (ack[i]),
      .running     (running[i]),
      .expired     (expired[i]),
      .irq_pending (irq_pending[i]),
      .count       (count[i*SIZE +: SIZE])
    );
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_timer_multi.sv
// Directed and randomized bench for timer_multi against a cycle-level
// behavioural model plus fixed expectations from the intended behaviour.
module tb_timer_multi;

  localparam int CH = 4;
  localparam int SZ = 32;
  localparam int PW = 8;
  localparam int DP = 20;

  logic              clock = 1'b0;
  logic              reset;
  logic [PW-1:0]     prescale;
  logic [CH-1:0]     start, stop, periodic, ack;
  logic [CH*SZ-1:0]  period;
  logic [CH-1:0]     running, expired, irq_pending;
  logic              irq;
  logic [CH*SZ-1:0]  count;

  int total = 0;
  int bad   = 0;
  int run_len, exp_at, n_exp, drops;

  // Behavioural model state: remaining ticks, latched period, mode, flags.
  int unsigned     m_psc = 0;
  longint unsigned m_cnt[CH];
  longint unsigned m_per[CH];
  bit              m_mode[CH];
  bit              m_exp[CH];
  bit              m_pend[CH];

  timer_multi #(
    .CHANNELS       (CH),
    .SIZE           (SZ),
    .PRESCALE_WIDTH (PW),
    .DEFAULT_PERIOD (DP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .prescale    (prescale),
    .start       (start),
    .stop        (stop),
    .periodic    (periodic),
    .period      (period),
    .ack         (ack),
    .running     (running),
    .expired     (expired),
    .irq_pending (irq_pending),
    .irq         (irq),
    .count       (count)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, int ch, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    bit tick;
    longint unsigned p;
    tick = (m_psc == int'(prescale));
    if (reset) begin
      m_psc = 0;
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_per[i] = 0; m_mode[i] = 0; m_exp[i] = 0; m_pend[i] = 0;
      end
    end else begin
      m_psc = tick ? 0 : (m_psc + 1) % 256;
      for (int i = 0; i < CH; i++) begin
        p = period[i*SZ +: SZ];
        m_exp[i] = 0;
        if (start[i]) begin
          m_per[i]  = (p == 0) ? DP : p;
          m_mode[i] = periodic[i];
          m_cnt[i]  = m_per[i];
        end else if (stop[i]) begin
          m_cnt[i] = 0;
        end else if (tick && m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_exp[i] = 1;
            if (m_mode[i]) m_cnt[i] = m_per[i];
          end
        end
        if (m_exp[i]) m_pend[i] = 1;
        else if (ack[i]) m_pend[i] = 0;
      end
    end
  endtask

  task automatic step();
    bit any;
    @(posedge clock);
    model_step();
    #1;
    any = 0;
    for (int i = 0; i < CH; i++) begin
      chk("count",   i, count[i*SZ +: SZ], m_cnt[i]);
      chk("running", i, running[i], m_cnt[i] != 0);
      chk("expired", i, expired[i], m_exp[i]);
      chk("pending", i, irq_pending[i], m_pend[i]);
      any |= m_pend[i];
    end
    chk("irq", 0, irq, any);
  endtask

  task automatic pulse_start(int ch, int unsigned p, bit mode);
    start[ch] = 1'b1;
    periodic[ch] = mode;
    period[ch*SZ +: SZ] = p;
    step();
    start[ch] = 1'b0;
  endtask

  task automatic align_prescale(logic [PW-1:0] val);
    for (int k = 0; k < 300 && m_psc != 0; k++) step();
    prescale = val;
  endtask

  initial begin
    reset = 1'b1; prescale = '0; start = '0; stop = '0; periodic = '0; ack = '0; period = '0;
    step(); step();
    chk("rst_running", 0, running, 0);
    chk("rst_count",   0, count[63:0], 0);
    chk("rst_irq",     0, irq, 0);
    reset = 1'b0;
    step();

    // One-shot, period 5, tick every clock.
    pulse_start(0, 5, 1'b0);
    run_len = running[0]; exp_at = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (running[0]) run_len++;
      if (expired[0] && exp_at == 0) exp_at = k;
    end
    chk("oneshot_run_len", 0, run_len, 5);
    chk("oneshot_exp_at",  0, exp_at, 5);
    chk("oneshot_pending", 0, irq_pending[0], 1);
    chk("oneshot_irq",     0, irq, 1);
    ack[0] = 1'b1; step(); ack[0] = 1'b0;

    // Periodic, period 3, then stop.
    pulse_start(1, 3, 1'b1);
    n_exp = 0; drops = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_exp += expired[1];
      if (!running[1]) drops++;
    end
    chk("periodic_pulses", 1, n_exp, 4);
    chk("periodic_drops",  1, drops, 0);
    stop[1] = 1'b1; step(); stop[1] = 1'b0;
    chk("stop_running", 1, running[1], 0);
    n_exp = 0;
    for (int k = 0; k < 6; k++) begin step(); n_exp += expired[1]; end
    chk("stop_no_pulse", 1, n_exp, 0);

    // Prescaled channel: expiry lands 5..8 clocks after start.
    prescale = 8'd3; step();
    pulse_start(2, 2, 1'b0);
    exp_at = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (expired[2] && exp_at == 0) exp_at = k;
    end
    chk("prescale_window", 2, (exp_at >= 5 && exp_at <= 8), 1);
    align_prescale(8'd0);

    // Retrigger mid-countdown, then start on the expiry edge.
    pulse_start(0, 10, 1'b0);
    for (int k = 0; k < 7; k++) step();
    pulse_start(0, 4, 1'b0);
    chk("retrigger_count", 0, count[0 +: SZ], 4);
    exp_at = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (expired[0] && exp_at == 0) exp_at = k;
    end
    chk("retrigger_exp_at", 0, exp_at, 4);
    pulse_start(0, 3, 1'b0);
    step(); step();
    pulse_start(0, 3, 1'b0);
    chk("start_on_expiry_pulse", 0, expired[0], 0);
    chk("start_on_expiry_count", 0, count[0 +: SZ], 3);
    for (int k = 0; k < 4; k++) step();
    ack = 4'hF; step(); ack = '0;

    // Default period and acknowledge around expiry.
    pulse_start(3, 0, 1'b0);
    chk("default_period", 3, count[3*SZ +: SZ], DP);
    for (int k = 0; k < DP - 1; k++) step();
    ack[3] = 1'b1; step();
    chk("ack_coincident_expired", 3, expired[3], 1);
    chk("ack_coincident_pending", 3, irq_pending[3], 1);
    step(); ack[3] = 1'b0;
    chk("ack_clears_pending", 3, irq_pending[3], 0);
    chk("ack_clears_irq",     0, irq, 0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < CH; i++) begin
        start[i]    = ($urandom_range(15) == 0);
        stop[i]     = ($urandom_range(31) == 0);
        ack[i]      = ($urandom_range(3) == 0);
        periodic[i] = $urandom_range(1);
        period[i*SZ +: SZ] = $urandom_range(12);
      end
      if (m_psc == 0 && $urandom_range(31) == 0) prescale = PW'($urandom_range(3));
      step();
    end
    start = '0; stop = '0; ack = '0;
    align_prescale(8'd0);

    // Reset while three channels are counting.
    ack = 4'hF; step(); ack = '0;
    start = 4'b0111; periodic = 4'b0111;
    for (int i = 0; i < 3; i++) period[i*SZ +: SZ] = 50;
    step();
    start = '0;
    for (int k = 0; k < 5; k++) step();
    chk("pre_reset_running", 0, running[2:0], 3'b111);
    reset = 1'b1; step(); reset = 1'b0;
    chk("reset_running", 0, running, 0);
    chk("reset_expired", 0, expired, 0);
    chk("reset_pending", 0, irq_pending, 0);
    chk("reset_irq",     0, irq, 0);
    chk("reset_count_lo", 0, count[63:0], 0);
    chk("reset_count_hi", 0, count[127:64], 0);
    n_exp = 0;
    for (int k = 0; k < 60; k++) begin step(); n_exp += (expired != '0); end
    chk("post_reset_no_pulse", 0, n_exp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
